// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the line, decodes 11-bit frames and queues bytes for reads.
// Optional PS2_RX_ERR_EN keeps bad frames with an error tag and reports FIFO overflow on the next pop.
module ps2_rx #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data_out,
    output logic        pending
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_C = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizers reset to 1 so an idle line never looks like a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    state_t        state, state_n;
    logic [7:0]    shift, shift_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          par_ok, par_ok_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          push;
    logic          push_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shift  <= '0;
            bitcnt <= '0;
            par_ok <= 1'b0;
            tmo    <= '0;
        end else begin
            state  <= state_n;
            shift  <= shift_n;
            bitcnt <= bitcnt_n;
            par_ok <= par_ok_n;
            tmo    <= tmo_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift;
        bitcnt_n = bitcnt;
        par_ok_n = par_ok;
        tmo_n    = '0;
        push     = 1'b0;
        push_err = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !bit_in) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_n  = {bit_in, shift[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_ok_n = ^{shift, bit_in};
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    push_err = ~(bit_in & par_ok);
`ifdef PS2_RX_ERR_EN
                    push     = 1'b1;
`else
                    push     = ~push_err;
`endif
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Mid-frame watchdog: a stalled device must not wedge the decoder.
        if (state != IDLE && !fall) begin
            if (tmo == TMO_LAST) state_n = IDLE;
            else tmo_n = tmo + TW'(1);
        end
    end

    // FIFO. A push into a full FIFO is accepted only when a pop frees a slot that same cycle.
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count, count_n;
    logic                       full, empty, pop, wr;
    logic [1:0]                 head_flags;
    logic [7:0]                 head_byte;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = ren & ~empty;
    assign wr    = push & (~full | pop);

    always_comb begin
        count_n = count;
        if (wr && !pop)      count_n = count + 1'b1;
        else if (pop && !wr) count_n = count - 1'b1;
    end

`ifdef PS2_RX_ERR_EN
    logic [8:0] mem [DEPTH];
    logic       ovf;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {push_err, shift};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   ovf <= 1'b0;
        else if (pop)              ovf <= 1'b0;
        else if (push && full)     ovf <= 1'b1;
    end

    assign head_flags = {mem[rd_ptr][8], ovf};
    assign head_byte  = mem[rd_ptr][7:0];
`else
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shift;
    end

    assign head_flags = 2'b00;
    assign head_byte  = mem[rd_ptr];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            pending  <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_n;
            pending <= (count_n != '0);
            if (ren) begin
                if (pop) data_out <= {1'b1, head_flags, 5'b0, head_byte};
                else     data_out <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: vector table, hand-written corner sequences and randomized frames against a queue model.
module tb_ps2_rx;
    localparam int TMO   = 200;
    localparam int HALF  = 6;
    localparam int SYNC  = 2;
    localparam int DEPTH = 16;
`ifdef PS2_RX_ERR_EN
    localparam bit ERR_MODE = 1'b1;
`else
    localparam bit ERR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ren = 1'b0;
    logic [15:0] data_out;
    logic        pending;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic        model_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_rx #(
        .FIFO_DEPTH_LOG2(4),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ren     (ren),
        .data_out(data_out),
        .pending (pending)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: odd parity over data+parity, stop must be 1.
    task automatic model_push(input logic [7:0] b, input logic par, input logic stop);
        logic good;
        good = (($countones(b) + int'(par)) % 2 == 1) && stop;
        if (good || ERR_MODE) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({1'b1, ~good, 6'b0, b});
            else if (ERR_MODE) model_ovf = 1'b1;
        end
    endtask

    function automatic logic [15:0] model_pop();
        logic [15:0] v;
        v = 16'h0000;
        if (exp_q.size() != 0) begin
            v = exp_q.pop_front();
            v[13] = model_ovf;
            model_ovf = 1'b0;
        end
        return v;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n, input bit ren_at_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (ren_at_last && i == n - 1) begin
                repeat (SYNC) @(posedge clk);
                @(negedge clk) ren = 1'b1;
                @(negedge clk) ren = 1'b0;
                check16("ren_at_stop_empty", data_out, 16'h0000);
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input bit ren_at_stop);
        send_bits({stop, par, b, 1'b0}, 11, ren_at_stop);
        repeat (4) @(negedge clk);
        model_push(b, par, stop);
    endtask

    task automatic pulse_ren();
        @(negedge clk) ren = 1'b1;
        @(negedge clk) ren = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [15:0] exp);
        logic [15:0] unused;
        pulse_ren();
        unused = model_pop();
        check16(name, data_out, exp);
        check16({name, "_pending"}, {15'b0, pending}, {15'b0, exp_q.size() != 0});
    endtask

    task automatic read_model(input string name);
        logic [15:0] exp;
        pulse_ren();
        exp = model_pop();
        check16(name, data_out, exp);
        check16({name, "_pending"}, {15'b0, pending}, {15'b0, exp_q.size() != 0});
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        par;
        logic        stop;
        logic [15:0] exp_def;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 16'h801C, 16'h801C};
        vecs[1] = '{8'h5A, 1'b0, 1'b1, 16'h0000, 16'hC05A};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 16'h805A, 16'h805A};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 16'h0000, 16'hC0FF};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 16'h8001, 16'h8001};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 16'h8000, 16'h8000};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 16'h80A5, 16'h80A5};

        // Reset and empty read
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check16("reset_data_out", data_out, 16'h0000);
        check16("reset_pending", {15'b0, pending}, 16'h0000);
        read_expect("empty_read", 16'h0000);

        // Vector table
        foreach (vecs[i]) begin
            logic [15:0] exp;
            exp = ERR_MODE ? vecs[i].exp_err : vecs[i].exp_def;
            send_frame(vecs[i].b, vecs[i].par, vecs[i].stop, 1'b0);
            check16($sformatf("vec%0d_pending", i), {15'b0, pending}, {15'b0, exp != 16'h0000});
            read_expect($sformatf("vec%0d_read", i), exp);
        end

        // Partial frame aborted by timeout
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        read_expect("timeout_read", 16'h805A);
        read_expect("timeout_empty", 16'h0000);

        // Overflow: 17 frames, 16 kept
        for (int i = 0; i < 17; i++) send_frame(8'(i), ~^8'(i), 1'b1, 1'b0);
        check16("full_pending", {15'b0, pending}, 16'h0001);
        for (int i = 0; i < 16; i++)
            read_expect($sformatf("ovf_read%0d", i),
                        (i == 0) ? (ERR_MODE ? 16'hA000 : 16'h8000) : (16'h8000 | 16'(i)));
        read_expect("ovf_read16", 16'h0000);

        // Reset in the middle of a frame
        send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 5, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check16("midreset_pending", {15'b0, pending}, 16'h0000);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        read_expect("midreset_read", 16'h80F0);
        read_expect("midreset_empty", 16'h0000);

        // Pop on the same cycle as the STOP-edge push into an empty FIFO
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        void'(model_pop());
        check16("same_cycle_pending", {15'b0, pending}, 16'h0001);
        exp_q.push_back(16'h803C);
        read_expect("same_cycle_next", 16'h803C);

        // Randomized traffic against the queue model
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                int nf;
                nf = $urandom_range(1, 3);
                for (int k = 0; k < nf; k++) begin
                    logic [7:0] b;
                    logic       par, stop;
                    b    = 8'($urandom_range(0, 255));
                    par  = ~^b ^ ($urandom_range(0, 3) == 0);
                    stop = ($urandom_range(0, 7) != 0);
                    send_frame(b, par, stop, 1'b0);
                end
            end else begin
                int nr;
                nr = $urandom_range(1, 4);
                for (int k = 0; k < nr; k++) read_model($sformatf("rand%0d_read%0d", it, k));
            end
        end
        while (exp_q.size() != 0) read_model("drain_read");
        read_model("drain_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver. It is the producer behind the memory-mapped PS2 register at 0xF000.
- Samples the external PS/2 clock and data lines and decodes 11-bit frames (start, 8 data bits LSB-first, odd parity, stop).
- Buffers received scan-code bytes in a FIFO.
- Returns one byte per read strobe on `data_out`, which drives the memory block's `ps2_data_in`.

Parameters:
- FIFO_DEPTH_LOG2, 4, FIFO holds 2^FIFO_DEPTH_LOG2 bytes (default 16).
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock line (asynchronous to clk)
- ps2_data  input  1  raw PS/2 data line (asynchronous to clk)
- ren  input  1  read/pop strobe; this is the memory block's `ps2_ren` (raddr1 == 0xF000 & ren)
- data_out  output  16  read value; bit15 = valid, bits7:0 = byte, other bits 0
- pending  output  1  FIFO non-empty

Behaviour:
- Reset: one clock; `rst` is asynchronous and active-high.
  - Clears synchronizers (to 1 = idle line), FSM (IDLE), shift register, bit counter, timeout counter and FIFO pointers/count.
  - `data_out` = 0x0000 and `pending` = 0 after reset.
  - Reset mid-frame discards the partial frame.
- Sync and edge detect:
  - `ps2_clk` and `ps2_data` each pass through SYNC_STAGES flops.
  - A falling edge is sync'd clk 1 in the previous cycle and 0 in the current cycle.
  - All sampling uses sync'd `ps2_data` in the falling-edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 go to DATA with bitcnt=0. An edge with data=1 is ignored (stays IDLE).
  - DATA: on each edge shift the data bit into bit7 of the shift register (shift right), so LSB-first arrives in order. After the 8th bit go to PARITY.
  - PARITY: on edge latch `par_ok` = (XOR of 8 data bits XOR sampled bit) == 1, then go to STOP.
  - STOP: on edge, if data=1 and `par_ok`, push the byte; otherwise drop it. Go to IDLE.
- Timeout: in DATA, PARITY or STOP, a counter increments every clk and clears on each falling edge. When it reaches TIMEOUT_CYCLES the FSM goes to IDLE and the partial frame is discarded. The counter is held at 0 in IDLE.
- FIFO:
  - Push when full: byte dropped, contents unchanged.
  - Pop on `ren`:
    - If non-empty, `data_out` <= {1'b1, 7'b0, head byte} at the `ren` edge and the head is removed.
    - If empty, `data_out` <= 0x0000.
  - `data_out` holds its value until the next `ren` cycle. This gives 1-cycle latency: the value is valid in the cycle after `ren`, which is when the memory block captures it.
  - Simultaneous push and pop, non-empty: both performed, count unchanged.
  - Simultaneous push and pop, empty: pop returns 0x0000; the pushed byte is retained (count becomes 1).
- `pending` is registered and equals count != 0.

Optional Feature:
- Macro: PS2_RX_ERR_EN.
- Defined:
  - A bad-parity or bad-stop frame is pushed instead of dropped, with an error tag stored alongside it; a pop of that entry returns `data_out` bit14=1.
  - A sticky overflow flag sets on a push-when-full, is reported in bit13 of the next successful pop, and clears on that pop.
- Undefined: bad frames are dropped, bits 14:13 are always 0, and no extra storage is built.

Test Plan:
- Reset, then pulse `ren` with no traffic -> `data_out` 0x0000 in the next cycle, `pending`=0.
- Frame byte 0x1C, parity 0, stop 1 -> `pending`=1; `ren` -> `data_out`=0x801C, then `pending`=0.
- Frame byte 0x5A with wrong parity 0 -> FIFO stays empty. With PS2_RX_ERR_EN: `ren` returns 0xC05A.
- Send 5 bits of a frame, idle for TIMEOUT_CYCLES+10, then a full frame 0x5A with parity 1 -> one entry; read returns 0x805A.
- Send 17 frames 0x00..0x10 with no reads -> 16 reads return 0x8000..0x800F, the 17th read returns 0x0000. With PS2_RX_ERR_EN: the first read is 0xA000.
- Assert `rst` during bit 4 of a frame, release, send 0xF0 with parity 1 -> a single read returns 0x80F0. Pulse `ren` on the same clk as the STOP edge with the FIFO empty -> that read returns 0x0000 and the next read returns the pushed byte.
